seq_minterm_detector: RTL and testbench
=======================================

SEQ_MINTERM_DETECTOR -- requirements
Module: seq_minterm_detector

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the sliding-window length in bits (legal range 2..8).
REQ-002 The block SHALL have parameter INIT_TBL, default 16'h68A4 (minterms 2,5,7,11,13,14), meaning the reset contents of the 2^WIDTH-entry truth table, where bit k is the entry for window value k.
REQ-003 The block SHALL have parameter CNT_W, default 8, meaning the match-counter width.
REQ-004 clk  in  1  -- sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  -- reset, synchronous and active-high.
REQ-006 din  in  1  -- serial data bit.
REQ-007 din_valid  in  1  -- din is sampled this cycle.
REQ-008 flush  in  1  -- discard window contents and restart filling.
REQ-009 tbl_wr  in  1  -- truth-table write strobe.
REQ-010 tbl_addr  in  WIDTH  -- truth-table entry index.
REQ-011 tbl_data  in  1  -- value to write to the entry.
REQ-012 cnt_clr  in  1  -- clear the match counter.
REQ-013 window  out  WIDTH  -- current shift window; the newest bit is at the LSB.
REQ-014 armed  out  1  -- window holds WIDTH valid bits.
REQ-015 match  out  1  -- single-cycle registered detect pulse.
REQ-016 match_cnt  out  CNT_W  -- saturating count of match pulses.

Function
REQ-017 The FSM SHALL have two states: FILL (armed=0) and RUN (armed=1).
REQ-018 On din_valid=1 with flush=0, window SHALL become {window[WIDTH-2:0], din} and the fill count SHALL increment.
REQ-019 FILL SHALL transition to RUN on the cycle the WIDTH-th valid bit since reset or flush is shifted in; RUN SHALL persist until flush or rst.
REQ-020 match SHALL be 1 exactly one cycle after a valid bit whose resulting window value v has tbl[v]=1, provided that bit completes or follows the fill; otherwise match SHALL be 0.
REQ-021 The detect latency SHALL be 1 cycle from the din_valid edge to match; back-to-back valid bits SHALL be able to produce match on consecutive cycles.
REQ-022 flush SHALL clear window to 0 and the fill count to 0, enter FILL, and force match to 0 on the next cycle; it SHALL NOT alter the table or match_cnt.
REQ-023 When flush and din_valid are asserted in the same cycle, flush SHALL win and the bit SHALL be discarded.
REQ-024 A table write SHALL take effect on the next edge; a lookup in the same cycle as a write to the same index SHALL use the old entry.
REQ-025 match_cnt SHALL increment by 1 per match pulse and SHALL saturate at 2^CNT_W-1 without wrap-around.
REQ-026 When cnt_clr and an increment coincide, cnt_clr SHALL win and the count SHALL become 0.
REQ-027 When din_valid=0, window, state and match_cnt SHALL hold, and match SHALL be 0.

Reset
REQ-028 On rst=1 at an edge: window=0, fill count=0, state=FILL, armed=0, match=0, match_cnt=0, table=INIT_TBL.
REQ-029 rst SHALL take priority over all other inputs; a rst arriving mid-fill or mid-RUN SHALL discard partial state identically.

Configuration
REQ-030 With macro SEQ_MINTERM_DETECTOR_CNT_EN defined, REQ-025/026 SHALL apply; without it, the counter logic SHALL be omitted, match_cnt SHALL be constant 0, cnt_clr SHALL be ignored, and all other behaviour SHALL be unchanged.

Verification
REQ-031 Defaults, reset, bits 0,1,0,1 (MSB first) -> armed=1 after the 4th bit, window=4'b0101, match=1 one cycle later, match_cnt=1.
REQ-032 Defaults, stream 0,0,1,0 -> window=4'b0010 but match=1 only on the cycle after the 4th bit; no match during the first 3 bits even if the partial window hits a table entry.
REQ-033 tbl_wr addr=4'b0000 data=1 in the same cycle as a valid bit completing window 0000 -> no match; the next 0 bit -> match=1.
REQ-034 Complete window 0101 then assert flush with din_valid=1 -> bit discarded, window=0, armed=0, match=0; match_cnt unchanged.
REQ-035 CNT_W=2, force 5 matches -> match_cnt sequence 1,2,3,3,3; cnt_clr coinciding with a 6th match -> match_cnt=0.
REQ-036 Assert rst mid-RUN while din_valid=1 -> next cycle all outputs at reset values and table=16'h68A4; repeat REQ-031 without the counter macro -> match_cnt stays 0.

Source files
------------

// File: rtl/seq_minterm_detector_if.sv
// seq_minterm_detector_if: serial-data, table-programming and result signals
// of the minterm detector. Master drives the i_* side, slave (the detector)
// drives the o_* side.
interface seq_minterm_detector_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             i_din;
  logic             i_din_valid;
  logic             i_flush;
  logic             i_tbl_wr;
  logic [WIDTH-1:0] i_tbl_addr;
  logic             i_tbl_data;
  logic             i_cnt_clr;
  logic [WIDTH-1:0] o_window;
  logic             o_armed;
  logic             o_match;
  logic [CNT_W-1:0] o_match_cnt;

  modport master (
    output i_din, i_din_valid, i_flush, i_tbl_wr, i_tbl_addr, i_tbl_data, i_cnt_clr,
    input  o_window, o_armed, o_match, o_match_cnt
  );

  modport slave (
    input  i_din, i_din_valid, i_flush, i_tbl_wr, i_tbl_addr, i_tbl_data, i_cnt_clr,
    output o_window, o_armed, o_match, o_match_cnt
  );
endinterface

// File: rtl/seq_minterm_detector.sv
// seq_minterm_detector: shifts serial bits into a WIDTH-bit window and flags a
// registered one-cycle match whenever the new window value selects a set entry
// of a writable 2^WIDTH-entry truth table. Matching only starts once the window
// has been completely filled since reset or flush.
//
// Optional feature: define SEQ_MINTERM_DETECTOR_CNT_EN to build the saturating
// match counter; without it o_match_cnt is tied to 0 and i_cnt_clr is unused.
//
// state  | meaning
// S_FILL | fewer than WIDTH valid bits since reset/flush, o_armed=0
// S_RUN  | window fully populated, lookups may raise o_match, o_armed=1
module seq_minterm_detector #(
  parameter int                      WIDTH    = 4,
  parameter logic [(1<<WIDTH)-1:0]   INIT_TBL = 16'h68A4,
  parameter int                      CNT_W    = 8
) (
  input logic                  i_clk,
  input logic                  i_rst,
  seq_minterm_detector_if.slave ifc
);
  localparam int                DEPTH     = 1 << WIDTH;
  localparam int                FC_W      = $clog2(WIDTH + 1);
  localparam logic [FC_W-1:0]   LAST_FILL = FC_W'(WIDTH - 1);

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_window;
  logic [FC_W-1:0]  r_fill_cnt;
  logic [DEPTH-1:0] r_tbl;
  logic             r_armed;
  logic             r_match;

  logic [WIDTH-1:0] w_next_window;
  logic             w_fill_done;
  logic             w_detect;

  // The lookup reads the table register before this edge's write lands, so a
  // write to the entry being looked up only affects later bits.
  assign w_next_window = {r_window[WIDTH-2:0], ifc.i_din};
  assign w_fill_done   = (r_state == S_RUN) || (r_fill_cnt == LAST_FILL);
  assign w_detect      = ifc.i_din_valid && !ifc.i_flush && w_fill_done &&
                         r_tbl[w_next_window];

  // Truth table: reset to INIT_TBL, single-entry writes; flush leaves it alone.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tbl <= INIT_TBL;
    end else if (ifc.i_tbl_wr) begin
      r_tbl[ifc.i_tbl_addr] <= ifc.i_tbl_data;
    end
  end

  // Fill/run sequencing, window shift and registered match/armed outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_FILL;
      r_window   <= '0;
      r_fill_cnt <= '0;
      r_armed    <= 1'b0;
      r_match    <= 1'b0;
    end else begin
      r_match <= w_detect;
      if (ifc.i_flush) begin
        r_state    <= S_FILL;
        r_window   <= '0;
        r_fill_cnt <= '0;
        r_armed    <= 1'b0;
      end else if (ifc.i_din_valid) begin
        r_window <= w_next_window;
        if (r_state == S_FILL) begin
          r_fill_cnt <= r_fill_cnt + FC_W'(1);
          if (r_fill_cnt == LAST_FILL) begin
            r_state <= S_RUN;
            r_armed <= 1'b1;
          end
        end
      end
    end
  end

  assign ifc.o_window = r_window;
  assign ifc.o_armed  = r_armed;
  assign ifc.o_match  = r_match;

`ifdef SEQ_MINTERM_DETECTOR_CNT_EN
  logic [CNT_W-1:0] r_match_cnt;

  // Counts on the same edge that raises o_match; clear beats increment and
  // the count sticks at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_match_cnt <= '0;
    end else if (ifc.i_cnt_clr) begin
      r_match_cnt <= '0;
    end else if (w_detect && (r_match_cnt != '1)) begin
      r_match_cnt <= r_match_cnt + CNT_W'(1);
    end
  end

  assign ifc.o_match_cnt = r_match_cnt;
`else
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = ifc.i_cnt_clr;
  assign ifc.o_match_cnt  = CNT_W'(0);
`endif
endmodule

// File: tb/tb_seq_minterm_detector.sv
// tb_seq_minterm_detector: directed checks of the minterm detector with the
// default table (minterms 2,5,7,11,13,14). A second instance with a 2-bit
// counter shares the stimulus to exercise counter saturation.
module tb_seq_minterm_detector;
`ifdef SEQ_MINTERM_DETECTOR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  seq_minterm_detector_if #(.WIDTH(4), .CNT_W(8)) ifc  ();
  seq_minterm_detector_if #(.WIDTH(4), .CNT_W(2)) ifc2 ();

  assign ifc2.i_din       = ifc.i_din;
  assign ifc2.i_din_valid = ifc.i_din_valid;
  assign ifc2.i_flush     = ifc.i_flush;
  assign ifc2.i_tbl_wr    = ifc.i_tbl_wr;
  assign ifc2.i_tbl_addr  = ifc.i_tbl_addr;
  assign ifc2.i_tbl_data  = ifc.i_tbl_data;
  assign ifc2.i_cnt_clr   = ifc.i_cnt_clr;

  seq_minterm_detector #(.WIDTH(4), .INIT_TBL(16'h68A4), .CNT_W(8)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .ifc   (ifc.slave)
  );

  seq_minterm_detector #(.WIDTH(4), .INIT_TBL(16'h68A4), .CNT_W(2)) u_dut2 (
    .i_clk (clk),
    .i_rst (rst),
    .ifc   (ifc2.slave)
  );

  always #5 clk = ~clk;

  function automatic int ec(input int n);
    return CNT_EN ? n : 0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] w, input logic a,
                         input logic m, input int c1, input int c2);
    chk({tag, ".window"}, 32'(ifc.o_window), 32'(w));
    chk({tag, ".armed"},  32'(ifc.o_armed),  32'(a));
    chk({tag, ".match"},  32'(ifc.o_match),  32'(m));
    chk({tag, ".match2"}, 32'(ifc2.o_match), 32'(m));
    chk({tag, ".cnt"},    32'(ifc.o_match_cnt),  32'(c1));
    chk({tag, ".cnt2"},   32'(ifc2.o_match_cnt), 32'(c2));
  endtask

  task automatic sbit(input logic b);
    ifc.i_din       = b;
    ifc.i_din_valid = 1'b1;
    cyc();
    ifc.i_din       = 1'b0;
    ifc.i_din_valid = 1'b0;
  endtask

  task automatic do_flush();
    ifc.i_flush = 1'b1;
    cyc();
    ifc.i_flush = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    ifc.i_din       = 1'b0;
    ifc.i_din_valid = 1'b0;
    ifc.i_flush     = 1'b0;
    ifc.i_tbl_wr    = 1'b0;
    ifc.i_tbl_addr  = '0;
    ifc.i_tbl_data  = 1'b0;
    ifc.i_cnt_clr   = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    chk_all("reset", 4'h0, 1'b0, 1'b0, 0, 0);

    // 0,1,0,1: the third bit gives 0010 (a table hit) while still filling
    sbit(1'b0); chk_all("f1_b1", 4'h0, 1'b0, 1'b0, 0, 0);
    sbit(1'b1); chk_all("f1_b2", 4'h1, 1'b0, 1'b0, 0, 0);
    sbit(1'b0); chk_all("f1_b3", 4'h2, 1'b0, 1'b0, 0, 0);
    sbit(1'b1); chk_all("f1_b4", 4'h5, 1'b1, 1'b1, ec(1), ec(1));
    cyc();      chk_all("f1_idle", 4'h5, 1'b1, 1'b0, ec(1), ec(1));

    // flush, then 0,0,1,0 completes window 0010
    do_flush(); chk_all("fl2", 4'h0, 1'b0, 1'b0, ec(1), ec(1));
    sbit(1'b0); chk_all("f2_b1", 4'h0, 1'b0, 1'b0, ec(1), ec(1));
    sbit(1'b0); chk_all("f2_b2", 4'h0, 1'b0, 1'b0, ec(1), ec(1));
    sbit(1'b1); chk_all("f2_b3", 4'h1, 1'b0, 1'b0, ec(1), ec(1));
    sbit(1'b0); chk_all("f2_b4", 4'h2, 1'b1, 1'b1, ec(2), ec(2));

    // back-to-back RUN bits; 2-bit counter saturates at 3
    sbit(1'b1); chk_all("run_5", 4'h5, 1'b1, 1'b1, ec(3), ec(3));
    sbit(1'b1); chk_all("run_B", 4'hB, 1'b1, 1'b1, ec(4), ec(3));
    sbit(1'b0); chk_all("run_6", 4'h6, 1'b1, 1'b0, ec(4), ec(3));
    sbit(1'b1); chk_all("run_D", 4'hD, 1'b1, 1'b1, ec(5), ec(3));
    ifc.i_cnt_clr = 1'b1;
    sbit(1'b1);
    ifc.i_cnt_clr = 1'b0;
    chk_all("run_clr", 4'hB, 1'b1, 1'b1, 0, 0);

    // table write on the cycle that completes window 0000
    do_flush(); chk_all("fl3", 4'h0, 1'b0, 1'b0, 0, 0);
    sbit(1'b0); sbit(1'b0); sbit(1'b0);
    chk_all("f3_b3", 4'h0, 1'b0, 1'b0, 0, 0);
    ifc.i_tbl_wr   = 1'b1;
    ifc.i_tbl_addr = 4'h0;
    ifc.i_tbl_data = 1'b1;
    sbit(1'b0);
    ifc.i_tbl_wr   = 1'b0;
    ifc.i_tbl_data = 1'b0;
    chk_all("wr_same", 4'h0, 1'b1, 1'b0, 0, 0);
    sbit(1'b0); chk_all("wr_next", 4'h0, 1'b1, 1'b1, ec(1), ec(1));

    // complete 0101, idle, then flush together with a valid bit
    do_flush();
    sbit(1'b0); sbit(1'b1); sbit(1'b0);
    chk_all("f4_b3", 4'h2, 1'b0, 1'b0, ec(1), ec(1));
    sbit(1'b1); chk_all("f4_b4", 4'h5, 1'b1, 1'b1, ec(2), ec(2));
    cyc();      chk_all("f4_idle", 4'h5, 1'b1, 1'b0, ec(2), ec(2));
    ifc.i_flush = 1'b1;
    sbit(1'b1);
    ifc.i_flush = 1'b0;
    chk_all("fl_vs_valid", 4'h0, 1'b0, 1'b0, ec(2), ec(2));

    // reset mid-RUN with a valid bit present
    sbit(1'b0); sbit(1'b1); sbit(1'b0); sbit(1'b1);
    chk_all("f5_b4", 4'h5, 1'b1, 1'b1, ec(3), ec(3));
    rst = 1'b1;
    sbit(1'b1);
    rst = 1'b0;
    chk_all("rst_run", 4'h0, 1'b0, 1'b0, 0, 0);

    // table entry 0 back to its reset value of 0
    sbit(1'b0); sbit(1'b0); sbit(1'b0);
    chk_all("f6_b3", 4'h0, 1'b0, 1'b0, 0, 0);
    sbit(1'b0); chk_all("f6_b4", 4'h0, 1'b1, 1'b0, 0, 0);

    // clear entry 5 while idle, then 0101 no longer matches; 1011 still does
    ifc.i_tbl_wr   = 1'b1;
    ifc.i_tbl_addr = 4'h5;
    ifc.i_tbl_data = 1'b0;
    cyc();
    ifc.i_tbl_wr   = 1'b0;
    chk_all("wr5_idle", 4'h0, 1'b1, 1'b0, 0, 0);
    do_flush();
    sbit(1'b0); sbit(1'b1); sbit(1'b0); sbit(1'b1);
    chk_all("f7_b4", 4'h5, 1'b1, 1'b0, 0, 0);
    sbit(1'b1); chk_all("f7_B", 4'hB, 1'b1, 1'b1, ec(1), ec(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
